// File: rtl/uart_img_rx_if.sv
// Pixel stream from the UART image receiver into the mnist input port,
// together with the frame status strobes.
interface uart_img_rx_if;
  logic [7:0] img_dout;
  logic       dout_vld;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  modport master (
    output img_dout,
    output dout_vld,
    output frame_done,
    output frame_err,
    output busy
  );

  modport slave (
    input img_dout,
    input dout_vld,
    input frame_done,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/uart_img_rx.sv
// 8N1 UART receiver that frames IMG_PIXELS bytes into one image and streams
// them pixel by pixel, discarding partial frames on line errors or stalls.
module uart_img_rx #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int IMG_PIXELS  = 784,
  parameter int GAP_TIMEOUT = 5_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          uart_rxd,
  uart_img_rx_if.master img
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int GAP_W    = (GAP_TIMEOUT > 2) ? $clog2(GAP_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TIMEOUT - 1);
  localparam logic [9:0]       PIX_LAST  = 10'(IMG_PIXELS - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  logic [1:0]       sync_r;
  logic             rxd_s;
  logic [2:0]       state_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic [9:0]       pix_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [7:0]       img_dout_r;
  logic             dout_vld_r;
  logic             frame_done_r;
  logic             frame_err_r;
  logic             busy_r;

  assign rxd_s = sync_r[1];

  // Two-flop synchronizer for the asynchronous serial line, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], uart_rxd};
    end
  end

  // Bit-level receive FSM, pixel framing and partial-frame gap timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      baud_cnt_r   <= '0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      pix_cnt_r    <= 10'd0;
      gap_cnt_r    <= '0;
      img_dout_r   <= 8'h00;
      dout_vld_r   <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      dout_vld_r   <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          baud_cnt_r <= '0;
          if (!rxd_s) begin
            state_r   <= ST_START;
            gap_cnt_r <= '0;
          end else if (pix_cnt_r != 10'd0) begin
            // A stalled host must not leave the core holding half an image.
            if (gap_cnt_r == GAP_LAST) begin
              pix_cnt_r   <= 10'd0;
              busy_r      <= 1'b0;
              frame_err_r <= 1'b1;
              gap_cnt_r   <= '0;
            end else begin
              gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end
          end else begin
            gap_cnt_r <= '0;
          end
        end
        ST_START: begin
          if (baud_cnt_r == HALF_LAST) begin
            baud_cnt_r <= '0;
            if (!rxd_s) begin
              state_r   <= ST_DATA;
              bit_idx_r <= 3'd0;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_cnt_r == BIT_LAST) begin
            baud_cnt_r         <= '0;
            shift_r[bit_idx_r] <= rxd_s;
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_cnt_r == BIT_LAST) begin
            baud_cnt_r <= '0;
            if (rxd_s) begin
              state_r    <= ST_IDLE;
              img_dout_r <= shift_r;
              dout_vld_r <= 1'b1;
              gap_cnt_r  <= '0;
              if (pix_cnt_r == PIX_LAST) begin
                pix_cnt_r    <= 10'd0;
                busy_r       <= 1'b0;
                frame_done_r <= 1'b1;
              end else begin
                pix_cnt_r <= pix_cnt_r + 10'd1;
                busy_r    <= 1'b1;
              end
            end else begin
              state_r     <= ST_WAIT_IDLE;
              pix_cnt_r   <= 10'd0;
              busy_r      <= 1'b0;
              frame_err_r <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          // Break conditions hold the line low; resume only once it idles.
          if (rxd_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign img.img_dout   = img_dout_r;
  assign img.dout_vld   = dout_vld_r;
  assign img.frame_done = frame_done_r;
  assign img.frame_err  = frame_err_r;
  assign img.busy       = busy_r;

endmodule
